// File: rtl/frogger_playfield_if.sv
// frogger_playfield_if: control pulses in, car/frog maps and status out
interface frogger_playfield_if;
  logic        step_en;
  logic        freeze;
  logic        move_l;
  logic        move_u;
  logic        move_d;
  logic        move_r;
  logic [63:0] red_array;
  logic [63:0] green_array;
  logic        crashed;
  logic        survived;
  modport master (
    output step_en, freeze, move_l, move_u, move_d, move_r,
    input  red_array, green_array, crashed, survived
  );
  modport slave (
    input  step_en, freeze, move_l, move_u, move_d, move_r,
    output red_array, green_array, crashed, survived
  );
endinterface

// File: rtl/frogger_playfield.sv
// frogger_playfield: 8x8 rotating car rows, single-frog movement, crash and round-complete detection
module frogger_playfield #(
  parameter logic [63:0] PATTERN    = 64'h89_66_F2_00_4B_62_C4_00,
  parameter logic [7:0]  MOVE_RIGHT = 8'b0110_0100
) (
  input logic                clk,
  input logic                reset,
  frogger_playfield_if.slave bus
);
  logic [63:0] red_q, red_d, rot, green;
  logic [2:0]  row_q, row_d, col_q, col_d;
  logic        crashed_q, crashed_d, overlap, ok, mv, surv;
  for (genvar r = 0; r < 8; r++) begin : g_row
    assign rot[8*r +: 8] = MOVE_RIGHT[r] ? {red_q[8*r], red_q[8*r+1 +: 7]}
                                         : {red_q[8*r +: 7], red_q[8*r+7]};
  end
  assign green = 64'd1 << {row_q, col_q};
  always_comb begin
    overlap   = |(green & red_q);
    ok        = ~bus.freeze & ~crashed_q;
    mv        = ok & $onehot({bus.move_l, bus.move_u, bus.move_d, bus.move_r});
    surv      = mv & bus.move_u & (row_q == 3'd7) & ~overlap;
    row_d     = surv ? 3'd0
              : (mv & bus.move_u & (row_q != 3'd7)) ? row_q + 3'd1
              : (mv & bus.move_d & (row_q != 3'd0)) ? row_q - 3'd1 : row_q;
    col_d     = surv ? 3'd3
              : (mv & bus.move_l) ? col_q + 3'd1
              : (mv & bus.move_r) ? col_q - 3'd1 : col_q;
    red_d     = surv ? PATTERN : (ok & bus.step_en) ? rot : red_q;
    crashed_d = crashed_q | overlap;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_q     <= PATTERN;
      row_q     <= 3'd0;
      col_q     <= 3'd3;
      crashed_q <= 1'b0;
    end else begin
      red_q     <= red_d;
      row_q     <= row_d;
      col_q     <= col_d;
      crashed_q <= crashed_d;
    end
  end
  assign bus.red_array   = red_q;
  assign bus.green_array = green;
  assign bus.crashed     = crashed_q;
  assign bus.survived    = surv;
endmodule

// File: tb/tb_frogger_playfield.sv
// tb_frogger_playfield: scoreboard bench running a default-pattern and an empty-pattern playfield in lockstep
module tb_frogger_playfield;
  localparam logic [63:0] PAT0 = 64'h8966F2004B62C400;
  localparam logic [63:0] PAT1 = 64'h0;
  localparam logic [7:0]  MR   = 8'b0110_0100;
  typedef struct {
    logic [63:0] red;
    logic [63:0] green;
    logic        crashed;
    logic        survived;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  frogger_playfield_if b0 ();
  frogger_playfield_if b1 ();
  frogger_playfield #(.PATTERN(PAT0), .MOVE_RIGHT(MR)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  frogger_playfield #(.PATTERN(PAT1), .MOVE_RIGHT(MR)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mred[2];
  int          fr[2];
  int          fc[2];
  bit          mcr[2];
  function automatic void mreset();
    mred[0] = PAT0;
    mred[1] = PAT1;
    for (int d = 0; d < 2; d++) begin
      fr[d]  = 0;
      fc[d]  = 3;
      mcr[d] = 1'b0;
    end
  endfunction
  function automatic exp_t snap(int d, bit sv);
    exp_t e;
    e.red      = mred[d];
    e.green    = 64'd0;
    e.green[8*fr[d]+fc[d]] = 1'b1;
    e.crashed  = mcr[d];
    e.survived = sv;
    return e;
  endfunction
  task automatic drive(bit st, bit fz, bit l, bit u, bit dn, bit r);
    logic [63:0] nr;
    bit ov, ok, one, sv;
    int src;
    {b0.step_en, b0.freeze, b0.move_l, b0.move_u, b0.move_d, b0.move_r} = {st, fz, l, u, dn, r};
    {b1.step_en, b1.freeze, b1.move_l, b1.move_u, b1.move_d, b1.move_r} = {st, fz, l, u, dn, r};
    for (int d = 0; d < 2; d++) begin
      ov  = mred[d][8*fr[d]+fc[d]];
      ok  = !fz && !mcr[d];
      one = (int'(l) + int'(u) + int'(dn) + int'(r)) == 1;
      sv  = ok && one && u && fr[d] == 7 && !ov;
      if (d == 0) q0.push_back(snap(0, sv));
      else q1.push_back(snap(1, sv));
      mcr[d] = mcr[d] | ov;
      if (sv) begin
        mred[d] = (d == 0) ? PAT0 : PAT1;
        fr[d] = 0;
        fc[d] = 3;
      end else if (ok) begin
        if (st) begin
          nr = mred[d];
          for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 8; cc++) begin
              src = MR[rr] ? (cc + 1) % 8 : (cc + 7) % 8;
              nr[8*rr+cc] = mred[d][8*rr+src];
            end
          mred[d] = nr;
        end
        if (one) begin
          if (l) fc[d] = (fc[d] + 1) % 8;
          if (r) fc[d] = (fc[d] + 7) % 8;
          if (u && fr[d] < 7) fr[d] = fr[d] + 1;
          if (dn && fr[d] > 0) fr[d] = fr[d] - 1;
        end
      end
    end
  endtask
  task automatic cyc(bit st, bit fz, bit l, bit u, bit dn, bit r);
    @(posedge clk);
    #2;
    drive(st, fz, l, u, dn, r);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    mreset();
    drive(0, 0, 0, 0, 0, 0);
    mreset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic cmp(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("red0", b0.red_array, e.red);
      cmp("green0", b0.green_array, e.green);
      cmp("crashed0", 64'(b0.crashed), 64'(e.crashed));
      cmp("survived0", 64'(b0.survived), 64'(e.survived));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("red1", b1.red_array, e.red);
      cmp("green1", b1.green_array, e.green);
      cmp("crashed1", 64'(b1.crashed), 64'(e.crashed));
      cmp("survived1", 64'(b1.survived), 64'(e.survived));
    end
  end
  initial begin
    int k;
    reset = 1'b1;
    {b0.step_en, b0.freeze, b0.move_l, b0.move_u, b0.move_d, b0.move_r} = '0;
    {b1.step_en, b1.freeze, b1.move_l, b1.move_u, b1.move_d, b1.move_r} = '0;
    mreset();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (8) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (5) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 1, 0, 0, 1);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (30) begin
      do_reset();
      repeat (40) begin
        k = $urandom_range(0, 9);
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            k == 0 || k == 6 || k == 7, k >= 3 && k <= 6, k == 2, k == 1 || k == 7);
      end
    end
    for (int t = 0; t < 10 && (q0.size() > 0 || q1.size() > 0); t++) @(posedge clk);
    @(posedge clk);
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
